// File: rtl/mig_sweep_ctrl.sv
// rtl/mig_sweep_ctrl.sv - time-multiplexed majority-inverter network truth-table sweeper
module mig_sweep_ctrl #(
    parameter int MAX_NODES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prog_we,
    input  logic [2:0]   prog_addr,
    input  logic [14:0]  prog_data,
    input  logic [3:0]   node_count,
    input  logic         out_inv,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] tt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [14:0]          prog_q [MAX_NODES];
    logic [3:0]           cnt_q;
    logic                 inv_q;
    logic [6:0]           m_q;
    logic [2:0]           n_q;
    logic [MAX_NODES-1:0] w_q;
    logic [127:0]         tt_q;
    logic                 err_q;

    logic                 count_ok;
    logic                 accept;
    logic                 last_node;
    logic [14:0]          word;
    logic                 op0, op1, op2;
    logic                 maj;

    // Operand value: minterm input, constant zero, or an earlier node of this minterm.
    function automatic logic operand(input logic [4:0] op, input logic [6:0] m,
                                     input logic [MAX_NODES-1:0] w);
        logic v;
        v = 1'b0;
        if (op[3:0] < 4'd7) begin
            v = m[op[2:0]];
        end else if (op[3] && (32'(op[2:0]) < MAX_NODES)) begin
            v = w[op[2:0]];
        end
        return v ^ op[4];
    endfunction

    assign count_ok  = (node_count != 4'd0) && (node_count <= 4'(MAX_NODES));
    assign accept    = (state_q == S_IDLE) && start && count_ok;
    assign last_node = ({1'b0, n_q} == (cnt_q - 4'd1));

    // Shared majority unit fed by the program word of the current node.
    always_comb begin
        word = prog_q[n_q];
        op0  = operand(word[4:0],   m_q, w_q);
        op1  = operand(word[9:5],   m_q, w_q);
        op2  = operand(word[14:10], m_q, w_q);
        maj  = (op0 & op1) | (op0 & op2) | (op1 & op2);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: sweep ends after the last node of minterm 127.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EVAL;
            S_EVAL:  if (last_node && (m_q == 7'd127)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; err comes from its own pulse register.
    always_comb begin
        busy = (state_q == S_EVAL);
        done = (state_q == S_DONE);
        err  = err_q;
        tt   = tt_q;
    end

    // Program RAM: writable whenever no sweep is running, including the start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                prog_q[i] <= 15'd0;
            end
        end else if (prog_we && (state_q != S_EVAL) && (32'(prog_addr) < MAX_NODES)) begin
            prog_q[prog_addr] <= prog_data;
        end
    end

    // Sweep datapath: minterm/node counters, node registers and truth table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            inv_q <= 1'b0;
            m_q   <= 7'd0;
            n_q   <= 3'd0;
            w_q   <= '0;
            tt_q  <= 128'd0;
        end else if (accept) begin
            cnt_q <= node_count;
            inv_q <= out_inv;
            m_q   <= 7'd0;
            n_q   <= 3'd0;
            w_q   <= '0;
            tt_q  <= 128'd0;
        end else if (state_q == S_EVAL) begin
            if (last_node) begin
                // Node registers restart from zero so forward references read 0.
                tt_q[m_q] <= maj ^ inv_q;
                w_q       <= '0;
                n_q       <= 3'd0;
                m_q       <= m_q + 7'd1;
            end else begin
                w_q[n_q] <= maj;
                n_q      <= n_q + 3'd1;
            end
        end
    end

    // Reject pulse for a start with an out-of-range node count while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start && !count_ok;
        end
    end

endmodule

// File: tb/tb_mig_sweep_ctrl.sv
// tb/tb_mig_sweep_ctrl.sv - directed self-checking bench for mig_sweep_ctrl
module tb_mig_sweep_ctrl;

    logic         clk;
    logic         rst_n;
    logic         prog_we;
    logic [2:0]   prog_addr;
    logic [14:0]  prog_data;
    logic [3:0]   node_count;
    logic         out_inv;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] tt;

    int vectors   = 0;
    int miscomp   = 0;

    // operand = {inv, sel}; word = {op2, op1, op0}; x_i = i, const0 = 7, w_j = 8+j
    localparam logic [14:0] P_W0    = {5'd4,  5'd3,  5'd0};
    localparam logic [14:0] P_W1    = {5'd8,  5'd1,  5'd0};
    localparam logic [14:0] P_W2    = {5'd9,  5'd6,  5'd5};
    localparam logic [14:0] P_W3    = {5'd8,  5'd2,  5'd1};
    localparam logic [14:0] P_W4    = {5'd11, 5'd10, 5'd0};
    localparam logic [14:0] P_W5    = {5'd12, 5'd9,  5'd2};
    localparam logic [14:0] P_ONE   = {5'd23, 5'd23, 5'd0};
    localparam logic [14:0] P_X0    = {5'd7,  5'd23, 5'd0};
    localparam logic [14:0] P_AND   = {5'd7,  5'd1,  5'd0};
    localparam logic [14:0] P_NX0   = {5'd7,  5'd7,  5'd16};

    logic [127:0] tt_six;
    logic [127:0] tt_ones;
    logic [127:0] tt_x0;
    logic [127:0] tt_and;

    mig_sweep_ctrl #(.MAX_NODES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .node_count (node_count),
        .out_inv    (out_inv),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .tt         (tt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [2:0] addr, input logic [14:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic prog_six();
        prog(3'd0, P_W0);
        prog(3'd1, P_W1);
        prog(3'd2, P_W2);
        prog(3'd3, P_W3);
        prog(3'd4, P_W4);
        prog(3'd5, P_W5);
    endtask

    // Start a sweep, optionally writing node 0 in the start cycle, optionally poking
    // node 0 plus a second start at cycle poke_cyc; returns done cycle and busy count.
    task automatic run(input logic [3:0] nc, input logic inv, input int poke_cyc,
                       input logic [14:0] poke_data, input logic wr_at_start,
                       output int dcyc, output int bcnt);
        node_count = nc;
        out_inv    = inv;
        start      = 1'b1;
        prog_we    = wr_at_start;
        prog_addr  = 3'd0;
        prog_data  = poke_data;
        step();
        dcyc = -1;
        bcnt = 0;
        for (int c = 1; c <= 1200; c++) begin
            prog_we = 1'b0;
            start   = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                dcyc = c;
                break;
            end
            if (c == poke_cyc) begin
                prog_we   = 1'b1;
                prog_addr = 3'd0;
                prog_data = poke_data;
                start     = 1'b1;
            end
            step();
        end
        prog_we = 1'b0;
        start   = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (busy !== 1'b0) begin miscomp++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscomp++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (err  !== 1'b0) begin miscomp++; $display("FAIL reset_err got %b want 0", err); end
        vectors++; if (tt !== 128'd0) begin miscomp++; $display("FAIL reset_tt got %h want 0", tt); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_six_node();
        int dcyc, bcnt;
        prog_six();
        run(4'd6, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_six) begin miscomp++; $display("FAIL six_tt got %h want %h", tt, tt_six); end
        vectors++; if (dcyc !== 769) begin miscomp++; $display("FAIL six_done_cycle got %0d want 769", dcyc); end
        vectors++; if (bcnt !== 768) begin miscomp++; $display("FAIL six_busy_cycles got %0d want 768", bcnt); end
        vectors++; if (done !== 1'b0) begin miscomp++; $display("FAIL six_done_width got %b want 0", done); end
    endtask

    task automatic test_single_node();
        int dcyc, bcnt;
        prog(3'd0, P_ONE);
        run(4'd1, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_ones) begin miscomp++; $display("FAIL one_tt got %h want %h", tt, tt_ones); end
        vectors++; if (dcyc !== 129) begin miscomp++; $display("FAIL one_done_cycle got %0d want 129", dcyc); end
        run(4'd1, 1'b1, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== 128'd0) begin miscomp++; $display("FAIL one_inv_tt got %h want 0", tt); end
        vectors++; if (dcyc !== 129) begin miscomp++; $display("FAIL one_inv_done_cycle got %0d want 129", dcyc); end
        prog(3'd0, P_X0);
        run(4'd1, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_x0) begin miscomp++; $display("FAIL x0_tt got %h want %h", tt, tt_x0); end
        prog(3'd0, P_AND);
        run(4'd1, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_and) begin miscomp++; $display("FAIL and_tt got %h want %h", tt, tt_and); end
        prog(3'd0, P_NX0);
        run(4'd1, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== 128'd0) begin miscomp++; $display("FAIL nx0_tt got %h want 0", tt); end
    endtask

    task automatic test_err();
        logic [127:0] tt_before;
        logic [3:0]   bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        tt_before = tt;
        for (int i = 0; i < 2; i++) begin
            node_count = bad[i];
            start      = 1'b1;
            step();
            start      = 1'b0;
            vectors++; if (err !== 1'b1) begin miscomp++; $display("FAIL err_pulse nc=%0d got %b want 1", bad[i], err); end
            vectors++; if (busy !== 1'b0) begin miscomp++; $display("FAIL err_busy nc=%0d got %b want 0", bad[i], busy); end
            step();
            vectors++; if (err !== 1'b0) begin miscomp++; $display("FAIL err_width nc=%0d got %b want 0", bad[i], err); end
            vectors++; if (tt !== tt_before) begin miscomp++; $display("FAIL err_tt nc=%0d got %h want %h", bad[i], tt, tt_before); end
        end
    endtask

    task automatic test_mid_run();
        int dcyc, bcnt;
        prog(3'd0, P_AND);
        run(4'd1, 1'b0, 50, P_ONE, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_and) begin miscomp++; $display("FAIL midwr_tt got %h want %h", tt, tt_and); end
        vectors++; if (dcyc !== 129) begin miscomp++; $display("FAIL midstart_done_cycle got %0d want 129", dcyc); end
        run(4'd1, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_and) begin miscomp++; $display("FAIL midwr_dropped got %h want %h", tt, tt_and); end
        run(4'd1, 1'b0, 0, P_ONE, 1'b1, dcyc, bcnt);
        vectors++; if (tt !== tt_ones) begin miscomp++; $display("FAIL startwr_tt got %h want %h", tt, tt_ones); end
    endtask

    task automatic test_reset_midrun();
        int dcyc, bcnt;
        prog_six();
        node_count = 4'd6;
        out_inv    = 1'b0;
        start      = 1'b1;
        step();
        start      = 1'b0;
        for (int c = 1; c < 300; c++) step();
        vectors++; if (busy !== 1'b1) begin miscomp++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscomp++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (tt !== 128'd0) begin miscomp++; $display("FAIL abort_tt got %h want 0", tt); end
        vectors++; if (done !== 1'b0) begin miscomp++; $display("FAIL abort_done got %b want 0", done); end
        step();
        rst_n = 1'b1;
        step();
        prog_six();
        run(4'd6, 1'b0, 0, 15'd0, 1'b0, dcyc, bcnt);
        vectors++; if (tt !== tt_six) begin miscomp++; $display("FAIL abort_rerun_tt got %h want %h", tt, tt_six); end
        vectors++; if (dcyc !== 769) begin miscomp++; $display("FAIL abort_rerun_done got %0d want 769", dcyc); end
    endtask

    initial begin
        tt_six  = 128'hfeeaeae8eeaaaa88eeaaaa88e8a8a880;
        tt_ones = {128{1'b1}};
        tt_x0   = {32{4'ha}};
        tt_and  = {32{4'h8}};
        rst_n      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 3'd0;
        prog_data  = 15'd0;
        node_count = 4'd0;
        out_inv    = 1'b0;
        start      = 1'b0;
        test_reset();
        test_six_node();
        test_single_node();
        test_err();
        test_mid_run();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
